// File: rtl/xcvr_ref_clk_out_gen.sv
// Glitch-free programmable even divider that forwards a reference clock off-chip.
// Start, stop and divisor changes occur only at phase boundaries, so no runt pulse reaches the pad.
module xcvr_ref_clk_out_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int GUARD       = 4,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    input  logic             DIV_LOAD,
    output logic             DIV_ACK,
    output logic             REF_CLK_OUT,
    output logic             REF_CLK_OUT_OE,
    output logic             RUNNING,
    output logic [CNT_W-1:0] RISE_CNT
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        STOPPING,
        DRAIN
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_active;
    logic [DIV_W-1:0] div_pending;
    logic [DIV_W-1:0] half_cnt;
    logic [GW-1:0]    guard_cnt;
    logic             pending;

    logic [DIV_W-1:0] div_clamped;
    logic             half_done;
    logic             guard_done;
    logic             stop_req;
    logic             quiet_state;

    assign div_clamped = (DIV == '0) ? DIV_W'(1) : DIV;
    assign half_done   = (half_cnt == div_active - DIV_W'(1));
    assign guard_done  = (guard_cnt == GW'(GUARD - 1));
    assign stop_req    = (state == STOPPING) || !EN;
    assign quiet_state = (state == IDLE) || (state == START) || (state == DRAIN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            REF_CLK_OUT    <= 1'b0;
            REF_CLK_OUT_OE <= 1'b0;
            RUNNING        <= 1'b0;
            DIV_ACK        <= 1'b0;
            RISE_CNT       <= '0;
            div_active     <= DIV_W'(DEFAULT_DIV);
            div_pending    <= DIV_W'(DEFAULT_DIV);
            pending        <= 1'b0;
            half_cnt       <= '0;
            guard_cnt      <= '0;
        end else begin
            DIV_ACK <= 1'b0;

            // With no edge on the pad, a pending divisor can be taken at once.
            if (quiet_state && pending) begin
                div_active <= div_pending;
                DIV_ACK    <= 1'b1;
                pending    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    REF_CLK_OUT <= 1'b0;
                    RUNNING     <= 1'b0;
                    half_cnt    <= '0;
                    guard_cnt   <= '0;
                    if (EN) begin
                        state          <= START;
                        REF_CLK_OUT_OE <= 1'b1;
                    end else begin
                        REF_CLK_OUT_OE <= 1'b0;
                    end
                end

                START: begin
                    if (!EN) begin
                        state     <= DRAIN;
                        guard_cnt <= '0;
                    end else if (guard_done) begin
                        state    <= RUN;
                        RUNNING  <= 1'b1;
                        half_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end

                RUN, STOPPING: begin
                    if (state == RUN && !EN && !REF_CLK_OUT) begin
                        // Stopping in a low phase just lengthens it.
                        state     <= DRAIN;
                        RUNNING   <= 1'b0;
                        guard_cnt <= '0;
                    end else if (half_done) begin
                        half_cnt    <= '0;
                        REF_CLK_OUT <= ~REF_CLK_OUT;
                        if (!REF_CLK_OUT) begin
                            RISE_CNT <= RISE_CNT + CNT_W'(1);
                        end else begin
                            if (pending) begin
                                div_active <= div_pending;
                                DIV_ACK    <= 1'b1;
                                pending    <= 1'b0;
                            end
                            if (stop_req) begin
                                state     <= DRAIN;
                                RUNNING   <= 1'b0;
                                guard_cnt <= '0;
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + DIV_W'(1);
                        if (stop_req) state <= STOPPING;
                    end
                end

                DRAIN: begin
                    REF_CLK_OUT <= 1'b0;
                    if (guard_done) begin
                        state          <= IDLE;
                        REF_CLK_OUT_OE <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + GW'(1);
                    end
                end

                default: state <= IDLE;
            endcase

            // NOTE: this sits after the apply logic so that, as the later non-blocking
            // assignment, a load in the same cycle keeps pending set for the next boundary.
            if (DIV_LOAD) begin
                div_pending <= div_clamped;
                pending     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xcvr_ref_clk_out_gen.sv
// Scoreboard bench: the driver queues the expected pad/status outputs per cycle
// and a negedge monitor pops and compares them against the DUT.
module tb_xcvr_ref_clk_out_gen;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        en       = 1'b0;
    logic        div_load = 1'b0;
    logic [7:0]  div      = 8'd0;
    logic        div_ack;
    logic        ref_clk_out;
    logic        ref_clk_out_oe;
    logic        running;
    logic [15:0] rise_cnt;

    xcvr_ref_clk_out_gen dut (
        .CLK            (clk),
        .RESET          (reset),
        .EN             (en),
        .DIV            (div),
        .DIV_LOAD       (div_load),
        .DIV_ACK        (div_ack),
        .REF_CLK_OUT    (ref_clk_out),
        .REF_CLK_OUT_OE (ref_clk_out_oe),
        .RUNNING        (running),
        .RISE_CNT       (rise_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [3:0]  pins;
        logic [15:0] rise;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] rise_m  = 16'd0;
    logic        prev_out = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check("pins{out,oe,running,ack}",
                  {28'd0, ref_clk_out, ref_clk_out_oe, running, div_ack}, {28'd0, mon_e.pins});
            check("rise_cnt", {16'd0, rise_cnt}, {16'd0, mon_e.rise});
        end
    end

    // Queue n cycles of expected outputs (as seen after each coming edge) and advance.
    task automatic run_cycles(input int n, input logic out, input logic oe_e,
                              input logic run_e, input logic ack_e);
        for (int i = 0; i < n; i++) begin
            if (reset) begin
                rise_m   = 16'd0;
                prev_out = 1'b0;
            end else begin
                if (out && !prev_out) rise_m++;
                prev_out = out;
            end
            sb.push_back('{cyc + 1, {out, oe_e, run_e, ack_e}, rise_m});
            @(posedge clk);
            #1;
            div_load = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        run_cycles(2, 0, 0, 0, 0);
        reset = 1'b0;

        // Start with default divisor 4: OE next cycle, 4 guard + 4 low, then period 8
        en = 1'b1;
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(4, 0, 1, 1, 0);
        for (int p = 0; p < 10; p++) begin
            run_cycles(4, 1, 1, 1, 0);
            run_cycles(4, 0, 1, 1, 0);
        end

        // Two loads in a high phase: full high phase, one ack at the fall, then div 2
        run_cycles(1, 1, 1, 1, 0);
        div = 8'd3; div_load = 1'b1;
        run_cycles(1, 1, 1, 1, 0);
        div = 8'd2; div_load = 1'b1;
        run_cycles(1, 1, 1, 1, 0);
        run_cycles(1, 1, 1, 1, 0);
        run_cycles(1, 0, 1, 1, 1);
        run_cycles(1, 0, 1, 1, 0);
        for (int p = 0; p < 3; p++) begin
            run_cycles(2, 1, 1, 1, 0);
            run_cycles(2, 0, 1, 1, 0);
        end

        // Back to div 4, then EN=0 on 2nd high cycle: full high, drain, idle
        run_cycles(1, 1, 1, 1, 0);
        div = 8'd4; div_load = 1'b1;
        run_cycles(1, 1, 1, 1, 0);
        run_cycles(1, 0, 1, 1, 1);
        run_cycles(3, 0, 1, 1, 0);
        run_cycles(1, 1, 1, 1, 0);
        en = 1'b0;
        run_cycles(3, 1, 1, 1, 0);
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(2, 0, 0, 0, 0);

        // Restart, then EN=0 in a low phase: immediate drain, no further rise
        en = 1'b1;
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(4, 0, 1, 1, 0);
        run_cycles(4, 1, 1, 1, 0);
        run_cycles(2, 0, 1, 1, 0);
        en = 1'b0;
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(2, 0, 0, 0, 0);

        // DIV=0 in IDLE clamps to 1: ack next cycle, then CLK/2 output
        div = 8'd0; div_load = 1'b1;
        run_cycles(1, 0, 0, 0, 0);
        run_cycles(1, 0, 0, 0, 1);
        run_cycles(1, 0, 0, 0, 0);
        en = 1'b1;
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(1, 0, 1, 1, 0);
        for (int p = 0; p < 4; p++) begin
            run_cycles(1, 1, 1, 1, 0);
            run_cycles(1, 0, 1, 1, 0);
        end

        // Reset while high (with a coinciding, discarded load); EN held: full restart at div 4
        run_cycles(1, 1, 1, 1, 0);
        reset = 1'b1; div = 8'd1; div_load = 1'b1;
        run_cycles(1, 0, 0, 0, 0);
        reset = 1'b0;
        run_cycles(4, 0, 1, 0, 0);
        run_cycles(4, 0, 1, 1, 0);
        run_cycles(4, 1, 1, 1, 0);
        run_cycles(4, 0, 1, 1, 0);
        run_cycles(4, 1, 1, 1, 0);

        repeat (2) @(posedge clk);
        #7;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
